// File: rtl/gray_pkg.sv
// gray_pkg: shared state type and Gray-code helpers for the Gray count receiver
package gray_pkg;

   typedef enum logic {ACQUIRE, TRACK} state_t;

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
      return b;
   endfunction

   function automatic logic [5:0] bit_changes(input logic [31:0] a, input logic [31:0] c);
      logic [31:0] x;
      logic [5:0]  n;
      x = a ^ c;
      n = '0;
      for (int i = 0; i < 32; i++) n = n + 6'(x[i]);
      return n;
   endfunction

endpackage

// File: rtl/gray_sync.sv
// gray_sync: multi-flop synchroniser for a Gray-coded bus crossing into clk
module gray_sync #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0][WIDTH-1:0] r;

   // shift the asynchronous bus through the flop chain
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r <= '0;
      else          r <= {r[SYNC_STAGES-2:0], d};

   assign q = r[SYNC_STAGES-1];

endmodule

// File: rtl/gray_count_rx.sv
// gray_count_rx: tracks position and direction from a synchronised Gray count, flagging multi-bit jumps
module gray_count_rx
   import gray_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int POS_WIDTH   = 16,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_CYCLES = 4
)(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WIDTH-1:0]     gray_in,
   input  logic                 clear,
   output logic [WIDTH-1:0]     bin_out,
   output logic                 step_valid,
   output logic                 step_dir,
   output logic [POS_WIDTH-1:0] position,
   output logic                 err,
   output logic [7:0]           err_count,
   output logic                 locked
);

   state_t                 state, state_nx;
   logic [WIDTH-1:0]       s, b, prev, cand, cand_nx, delta;
   logic [3:0]             cnt, cnt_nx;
   logic [SYNC_STAGES-1:0] fill;
   logic [5:0]             n_chg;
   logic                   take, step_nx, err_nx, dir_nx, lock_nx;

   gray_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (gray_in),
      .q       (s)
   );

   assign b     = WIDTH'(gray2bin(32'(s)));
   assign n_chg = bit_changes(32'(s), 32'(prev));
   assign delta = b - bin_out;

   // acquire/track decision; lock counting waits until the sync chain holds real samples
   always_comb begin
      state_nx = state;
      cand_nx  = cand;
      cnt_nx   = cnt;
      take     = 1'b0;
      step_nx  = 1'b0;
      err_nx   = 1'b0;
      dir_nx   = step_dir;
      lock_nx  = locked;
      if (state == ACQUIRE) begin
         if (fill[SYNC_STAGES-1]) begin
            cnt_nx  = (s == cand) ? cnt + 4'd1 : 4'd1;
            cand_nx = s;
            if (cnt_nx >= 4'(LOCK_CYCLES)) begin
               take     = 1'b1;
               lock_nx  = 1'b1;
               state_nx = TRACK;
            end
         end
      end else if (n_chg == 6'd1) begin
         take    = 1'b1;
         step_nx = 1'b1;
         dir_nx  = (delta == WIDTH'(1));
      end else if (n_chg > 6'd1) begin
         err_nx   = 1'b1;
         lock_nx  = 1'b0;
         state_nx = ACQUIRE;
         cand_nx  = s;
         cnt_nx   = 4'd1;
      end
   end

   // register FSM, tracked sample, pulses and the clearable accumulators
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state      <= ACQUIRE;
         cand       <= '0;
         cnt        <= '0;
         fill       <= '0;
         prev       <= '0;
         bin_out    <= '0;
         step_valid <= 1'b0;
         step_dir   <= 1'b0;
         err        <= 1'b0;
         locked     <= 1'b0;
         position   <= '0;
         err_count  <= '0;
      end else begin
         state      <= state_nx;
         cand       <= cand_nx;
         cnt        <= cnt_nx;
         fill       <= {fill[SYNC_STAGES-2:0], 1'b1};
         if (take) begin
            prev    <= s;
            bin_out <= b;
         end
         step_valid <= step_nx;
         step_dir   <= dir_nx;
         err        <= err_nx;
         locked     <= lock_nx;
         position   <= clear ? '0 :
                       step_nx ? (dir_nx ? position + POS_WIDTH'(1) : position - POS_WIDTH'(1)) :
                       position;
         err_count  <= clear ? '0 :
                       (err_nx && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
      end

endmodule

// File: tb/tb_gray_count_rx.sv
// tb_gray_count_rx: table-driven and scoreboard check of the Gray count receiver
module tb_gray_count_rx;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  gray_in;
   logic        clear;
   logic [3:0]  bin_out;
   logic        step_valid, step_dir, err, locked;
   logic [15:0] position;
   logic [7:0]  err_count;

   typedef struct {logic [3:0] g; logic [3:0] bin; logic [15:0] pos; logic dir;} vec_t;
   typedef struct {logic is_err; logic dir; logic [3:0] bin; logic [15:0] pos; logic [7:0] ec;} exp_t;

   int          n_chk = 0;
   int          n_fail = 0;
   exp_t        sb[$];
   exp_t        e;
   vec_t        up_t[16], dn_t[16];
   logic [3:0]  gc[16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                           4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
   logic [15:0] pos_m;
   logic [7:0]  ec_m;
   logic [3:0]  bin_m;
   logic        dir_m;

   gray_count_rx dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .gray_in    (gray_in),
      .clear      (clear),
      .bin_out    (bin_out),
      .step_valid (step_valid),
      .step_dir   (step_dir),
      .position   (position),
      .err        (err),
      .err_count  (err_count),
      .locked     (locked)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // every pulse must match the oldest expected event
   always @(negedge clk) begin
      if (step_valid && err) begin
         n_chk++;
         n_fail++;
         $display("FAIL pulse_overlap: step_valid and err both high");
      end
      if (step_valid || err) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: step_valid=%0b err=%0b", step_valid, err);
         end else begin
            e = sb.pop_front();
            if ({err, step_dir, bin_out, position, err_count} !== {e.is_err, e.dir, e.bin, e.pos, e.ec}) begin
               n_fail++;
               $display("FAIL event: got err=%0b dir=%0b bin=%0h pos=%0h ec=%0d expected err=%0b dir=%0b bin=%0h pos=%0h ec=%0d",
                        err, step_dir, bin_out, position, err_count, e.is_err, e.dir, e.bin, e.pos, e.ec);
            end
         end
      end
   end

   task automatic run_vec(input vec_t v);
      gray_in = v.g;
      sb.push_back('{1'b0, v.dir, v.bin, v.pos, ec_m});
      pos_m = v.pos;
      bin_m = v.bin;
      dir_m = v.dir;
      repeat (4) tick();
      check("step_drained", 32'(sb.size()), 32'd0);
   endtask

   task automatic step_to(input logic [3:0] g, input logic [3:0] bin, input logic dir);
      vec_t v;
      v = '{g, bin, dir ? pos_m + 16'd1 : pos_m - 16'd1, dir};
      run_vec(v);
   endtask

   task automatic do_clear;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      pos_m = '0;
      ec_m  = '0;
      check("clear_pos", 32'(position), 32'd0);
      check("clear_ec", 32'(err_count), 32'd0);
   endtask

   task automatic err_to(input logic [3:0] g, input logic [3:0] bin_new);
      int n;
      ec_m = (ec_m == 8'hFF) ? 8'hFF : ec_m + 8'd1;
      sb.push_back('{1'b1, dir_m, bin_m, pos_m, ec_m});
      gray_in = g;
      repeat (3) tick();
      check("err_unlock", 32'(locked), 32'd0);
      n = 1;
      while (!locked && n < 12) begin
         tick();
         n++;
      end
      check("relock_edges", 32'(n), 32'd4);
      check("relock_bin", 32'(bin_out), 32'(bin_new));
      bin_m = bin_new;
      check("err_drained", 32'(sb.size()), 32'd0);
   endtask

   task automatic wait_lock;
      int n;
      n = 0;
      while (!locked && n < 20) begin
         tick();
         n++;
      end
      check("lock_edges", 32'(n), 32'd6);
      check("lock_bin", 32'(bin_out), 32'd0);
      check("lock_pos", 32'(position), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         up_t[i] = '{gc[(i + 1) % 16], 4'((i + 1) % 16), 16'(i + 1), 1'b1};
         dn_t[i] = '{gc[15 - i], 4'(15 - i), 16'hFFFF - 16'(i), 1'b0};
      end
      pos_m = '0;
      ec_m  = '0;
      bin_m = '0;
      dir_m = 1'b0;
      reset_n = 1'b0;
      gray_in = 4'h0;
      clear   = 1'b0;
      repeat (3) tick();
      check("rst_outputs", {bin_out, step_valid, step_dir, position, err, err_count, locked}, 32'd0);
      reset_n = 1'b1;
      wait_lock();
      for (int i = 0; i < 16; i++) run_vec(up_t[i]);
      check("up_pos", 32'(position), 32'd16);
      check("up_bin", 32'(bin_out), 32'd0);
      check("up_dir", 32'(step_dir), 32'd1);
      do_clear();
      for (int i = 0; i < 16; i++) run_vec(dn_t[i]);
      check("dn_pos", 32'(position), 32'hFFF0);
      check("dn_dir", 32'(step_dir), 32'd0);
      step_to(4'h1, 4'd1, 1'b1);
      step_to(4'h3, 4'd2, 1'b1);
      err_to(4'h6, 4'd4);
      check("err_count_one", 32'(err_count), 32'd1);
      check("err_pos_hold", 32'(position), 32'hFFF2);
      do_clear();
      step_to(4'h7, 4'd5, 1'b1);
      step_to(4'h5, 4'd6, 1'b1);
      step_to(4'h4, 4'd7, 1'b1);
      step_to(4'hC, 4'd8, 1'b1);
      step_to(4'hD, 4'd9, 1'b1);
      check("pre_clear_pos", 32'(position), 32'd5);
      gray_in = 4'hF;
      sb.push_back('{1'b0, 1'b1, 4'd10, 16'd0, ec_m});
      repeat (2) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      pos_m = '0;
      bin_m = 4'd10;
      dir_m = 1'b1;
      check("clr_step_valid", 32'(step_valid), 32'd1);
      check("clr_step_pos", 32'(position), 32'd0);
      tick();
      check("clr_drained", 32'(sb.size()), 32'd0);
      for (int i = 0; i < 256; i++) err_to(i % 2 == 0 ? 4'hC : 4'hF, i % 2 == 0 ? 4'd8 : 4'd10);
      check("err_sat", 32'(err_count), 32'd255);
      #3;
      reset_n = 1'b0;
      gray_in = 4'h0;
      #1;
      check("async_rst", {bin_out, step_valid, step_dir, position, err, err_count, locked}, 32'd0);
      pos_m = '0;
      ec_m  = '0;
      bin_m = '0;
      dir_m = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      wait_lock();
      check("final_ec", 32'(err_count), 32'd0);
      repeat (4) tick();
      check("final_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_count_rx.md
# gray_count_rx

Receive end of the 4-bit Gray counter link: samples a free-running Gray-coded count from another clock domain and turns it into a tracked position. The block resynchronises the bus, decodes Gray to binary and qualifies every change as a legal ±1 step or a multi-bit error. It accumulates a wrapping position and counts errors. It sits between the Gray counter output and any consumer that needs binary position and direction.

## Interface
- WIDTH, 4: Gray bus width.
- POS_WIDTH, 16: position accumulator width.
- SYNC_STAGES, 2: synchroniser depth, ≥2.
- LOCK_CYCLES, 4: consecutive identical synchronised samples required to lock, 1..15.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- gray_in  in  WIDTH  Gray count, asynchronous to clk.
- clear  in  1  synchronous clear of position and err_count.
- bin_out  out  WIDTH  binary value of the last accepted sample.
- step_valid  out  1  one-cycle pulse on an accepted ±1 step.
- step_dir  out  1  direction of the last step: 1 up, 0 down; holds between steps.
- position  out  POS_WIDTH  running step total, mod 2^POS_WIDTH.
- err  out  1  one-cycle pulse on a multi-bit change.
- err_count  out  8  error total, saturates at 255.
- locked  out  1  high while in TRACK.

## Operation
- Reset (async assert, sync release by the system): all synchroniser stages, prev, bin_out, position, err_count, and the lock counter go to 0. step_valid, step_dir, err, and locked go to 0. State goes to ACQUIRE.
- The synchronised sample s is the last stage of the SYNC_STAGES flop chain. b = gray2bin(s), with b[i] = XOR of s[WIDTH-1:i].
- ACQUIRE:
  - If s == candidate, the lock counter increments. Otherwise candidate <= s and the counter resets to 1.
  - When the counter reaches LOCK_CYCLES: prev <= s, bin_out <= b, locked <= 1, state goes to TRACK.
  - No step_valid or err pulses in ACQUIRE; position is unchanged.
- TRACK, comparing s with prev:
  - Equal: no action.
  - Exactly one bit differs: prev <= s and bin_out <= b. step_valid pulses. step_dir = 1 if (b − bin(prev)) mod 2^WIDTH == 1, else 0. position increments or decrements by 1.
  - Two or more bits differ:
    - err pulses; err_count increments, saturating at 255.
    - position, bin_out, and step_dir are unchanged.
    - locked <= 0, state goes to ACQUIRE, with candidate <= s and counter = 1.
- Wrap-around: Gray 1000→0000 (binary 15→0) is an up step; 0000→1000 is a down step. Position wraps modulo 2^POS_WIDTH in both directions.
- clear:
  - Sets position to 0 and err_count to 0 on the same edge.
  - It has priority over a simultaneous step or error increment; the step_valid or err pulse itself still fires.
  - It does not affect state, bin_out, or locked.

## Timing
- Sync chain latency: a gray_in value meeting setup at edge E is first in s after edge E+SYNC_STAGES−1.
- Step latency: the TRACK decision registers at edge E+SYNC_STAGES. bin_out, step_valid, step_dir, and position are updated after that edge, i.e. SYNC_STAGES+1 edges inclusive of the capture edge.
- The err pulse has the same latency as a step.
- After reset release with a stable input, locked rises after SYNC_STAGES+LOCK_CYCLES edges.
- At most one step is accepted per clock. Input changes faster than one per clock are outside contract and are reported as err.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- The shared package gray_pkg holds:
  - the state enum (ACQUIRE, TRACK);
  - the function gray2bin(WIDTH-generic);
  - the function bit-change count (popcount of XOR).
- Sub-module gray_sync: a parameterised SYNC_STAGES flop chain on a WIDTH bus, reset to 0. It holds the synchronisation attributes.
- The top level contains the FSM, lock counter, accumulator, and error counter.

## Test plan
- Reset then hold gray_in=0000: locked rises at edge 6 (defaults); bin_out=0, position=0, no pulses.
- Locked, then Gray up-sequence 0000,0001,0011,…,1000,0000 (16 steps), one value every 4 cycles: 16 step_valid pulses, step_dir=1, position=16, bin_out=0.
- Same sequence in reverse from 0000 (0000→1000→1001…): step_dir=0, position=0xFFFF after the first step, 0xFFF0 after 16 steps.
- Locked at 0011, jump to 0110 (2 bits): err pulse, err_count=1, locked=0, position unchanged; relocks 4 cycles later with bin_out=4.
- clear asserted on the same edge as an accepted up step with position=5: position=0, step_valid=1; 256 forced errors leave err_count=255.
- Assert reset_n low mid-sequence, asynchronous to clk: all outputs 0 immediately; reacquisition as in scenario 1.
